// File: rtl/reg_ring_rotator_if.sv
// Bundle of load / run-control handshakes and ring observation outputs for reg_ring_rotator.
// Handshake: a load transfers on a posedge where load_valid && load_ready; start is a one-cycle pulse honoured only in IDLE.
interface reg_ring_rotator_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_a;
  logic [WIDTH-1:0] load_b;
  logic [WIDTH-1:0] load_c;
  logic             start;
  logic             dir;
  logic [3:0]       count;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH-1:0] c_out;
  logic [15:0]      total_steps;
  logic [1:0]       state_dbg;

  modport master (
    output load_valid, load_a, load_b, load_c, start, dir, count,
    input  load_ready, busy, done, a_out, b_out, c_out, total_steps, state_dbg
  );

  modport slave (
    input  load_valid, load_a, load_b, load_c, start, dir, count,
    output load_ready, busy, done, a_out, b_out, c_out, total_steps, state_dbg
  );
endinterface

// File: rtl/reg_ring_rotator.sv
// Three-register ring that rotates forward (a<-b<-c<-a) or reverse a requested number of steps.
// Tracks a free-running 16-bit total of applied steps; state is exported on state_dbg.
module reg_ring_rotator #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_ring_rotator_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] reg_c;
  logic [3:0]       remaining;
  logic             dir_q;
  logic [15:0]      total_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A load in the same cycle as start wins; the start is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!bus.load_valid && bus.start) begin
          state_nxt = (bus.count == 4'd0) ? DONE : ROTATE;
        end
      end
      ROTATE: begin
        if (remaining == 4'd1) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a     <= '0;
      reg_b     <= '0;
      reg_c     <= '0;
      remaining <= 4'd0;
      dir_q     <= 1'b0;
      total_q   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            reg_a <= bus.load_a;
            reg_b <= bus.load_b;
            reg_c <= bus.load_c;
          end else if (bus.start && bus.count != 4'd0) begin
            remaining <= bus.count;
            dir_q     <= bus.dir;
          end
        end
        ROTATE: begin
          if (dir_q) begin
            reg_a <= reg_c;
            reg_b <= reg_a;
            reg_c <= reg_b;
          end else begin
            reg_a <= reg_b;
            reg_b <= reg_c;
            reg_c <= reg_a;
          end
          remaining <= remaining - 4'd1;
          total_q   <= total_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.load_ready  = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.a_out       = reg_a;
  assign bus.b_out       = reg_b;
  assign bus.c_out       = reg_c;
  assign bus.total_steps = total_q;
  assign bus.state_dbg   = state;

endmodule
